// File: rtl/fpu_muldiv.sv
// fpu_muldiv: iterative multiply / divide / square root on sign-exponent-mantissa operands.
// Latency: MAN_W+3 cycles from an accepted start to done, or 2 cycles for special or illegal operands.
// Backpressure: none; start is sampled only while idle and is otherwise ignored, with no queueing.
module fpu_muldiv #(
    parameter int EXP_W = 7,
    parameter int MAN_W = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             a_s,
    input  logic             b_s,
    input  logic [EXP_W-1:0] a_e,
    input  logic [EXP_W-1:0] b_e,
    input  logic [MAN_W-1:0] a_m,
    input  logic [MAN_W-1:0] b_m,
    output logic             res_s,
    output logic [EXP_W-1:0] res_e,
    output logic [MAN_W-1:0] res_m,
    output logic             zero_flag,
    output logic             overflow_flag,
    output logic             underflow_flag,
    output logic             div_zero_flag,
    output logic             invalid_flag,
    output logic             idle,
    output logic             done
);

    // Exponents are widened by two bits so that sums and differences of
    // two in-range exponents (plus normalisation steps) never wrap.
    localparam int XW    = EXP_W + 2;
    localparam int CNT_W = $clog2(MAN_W + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAN_W - 1);
    localparam logic [EXP_W-1:0] E_ZERO   = {1'b1, {(EXP_W-1){1'b0}}};
    localparam logic [EXP_W-1:0] E_INF    = {1'b0, {(EXP_W-1){1'b1}}};
    localparam logic [MAN_W-1:0] M_ONE    = {1'b1, {(MAN_W-1){1'b0}}};

    localparam logic signed [XW-1:0] E_MAX  = XW'((2 ** (EXP_W - 1)) - 2);
    localparam logic signed [XW-1:0] E_MIN  = XW'(1 - (2 ** (EXP_W - 1)));
    localparam logic signed [XW-1:0] X_ONE  = XW'(1);
    localparam logic signed [XW-1:0] X_ZERO = XW'(0);

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_SQRT = 2'b10;

    // Flag vector bit positions: {invalid, div_zero, underflow, overflow, zero}
    localparam int F_ZERO = 0;
    localparam int F_OVF  = 1;
    localparam int F_UNF  = 2;
    localparam int F_DZ   = 3;
    localparam int F_INV  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ITER,
        S_NORM,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [1:0]              op_q, op_d;
    logic                    a_s_q, a_s_d;
    logic                    b_s_q, b_s_d;
    logic [EXP_W-1:0]        a_e_q, a_e_d;
    logic [EXP_W-1:0]        b_e_q, b_e_d;
    logic [MAN_W-1:0]        a_m_q, a_m_d;
    logic [MAN_W-1:0]        b_m_q, b_m_d;
    logic signed [XW-1:0]    exp_q, exp_d;
    // Mul: running product. Sqrt: radicand shifted out two bits per step.
    logic [2*MAN_W-1:0]      prod_q, prod_d;
    // Div/sqrt partial remainder.
    logic [MAN_W+2:0]        rem_q, rem_d;
    // Div quotient or sqrt root, built MSB first.
    logic [MAN_W-1:0]        quo_q, quo_d;

    // Result staged during CHECK/NORM, published on the edge leaving DONE.
    logic                    pr_s_q, pr_s_d;
    logic [EXP_W-1:0]        pr_e_q, pr_e_d;
    logic [MAN_W-1:0]        pr_m_q, pr_m_d;
    logic [4:0]              pflg_q, pflg_d;

    logic                    res_s_q, res_s_d;
    logic [EXP_W-1:0]        res_e_q, res_e_d;
    logic [MAN_W-1:0]        res_m_q, res_m_d;
    logic [4:0]              flg_q, flg_d;
    logic                    done_q, done_d;

    // Operand classification. Zero and infinity are identified by their
    // reserved exponent codes alone; no finite value uses those codes.
    logic                    a_zero, b_zero, a_inf, b_inf;
    logic                    sgn;
    logic signed [XW-1:0]    a_ex, b_ex, sq_ex;

    assign a_zero = (a_e_q == E_ZERO);
    assign b_zero = (b_e_q == E_ZERO);
    assign a_inf  = (a_e_q == E_INF);
    assign b_inf  = (b_e_q == E_INF);
    assign sgn    = op_q[1] ? 1'b1 : (a_s_q == b_s_q);
    assign a_ex   = {{2{a_e_q[EXP_W-1]}}, a_e_q};
    assign b_ex   = {{2{b_e_q[EXP_W-1]}}, b_e_q};
    // Odd sqrt exponents are made even by doubling the radicand mantissa.
    assign sq_ex  = a_ex - (a_e_q[0] ? X_ONE : X_ZERO);

    // One iteration step for each operation.
    logic [MAN_W:0]          mul_sum;
    logic                    div_ge;
    logic [MAN_W+2:0]        div_sub;
    logic [MAN_W+2:0]        sq_rem, sq_trial;
    logic                    sq_ge;

    assign mul_sum  = {1'b0, prod_q[2*MAN_W-1:MAN_W]} + (prod_q[0] ? {1'b0, a_m_q} : '0);
    assign div_ge   = (rem_q >= {3'b000, b_m_q});
    assign div_sub  = div_ge ? (rem_q - {3'b000, b_m_q}) : rem_q;
    assign sq_rem   = {rem_q[MAN_W:0], prod_q[2*MAN_W-1:2*MAN_W-2]};
    assign sq_trial = {1'b0, quo_q, 2'b01};
    assign sq_ge    = (sq_rem >= sq_trial);

    // Scratch values for special-case and range resolution.
    logic                    sp_inv, sp_zero, sp_inf, sp_dz;
    logic signed [XW-1:0]    nexp;
    logic [MAN_W-1:0]        nman;

    // Next-state, datapath and result computation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_s_d    = a_s_q;
        b_s_d    = b_s_q;
        a_e_d    = a_e_q;
        b_e_d    = b_e_q;
        a_m_d    = a_m_q;
        b_m_d    = b_m_q;
        exp_d    = exp_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        pr_s_d   = pr_s_q;
        pr_e_d   = pr_e_q;
        pr_m_d   = pr_m_q;
        pflg_d   = pflg_q;
        res_s_d  = res_s_q;
        res_e_d  = res_e_q;
        res_m_d  = res_m_q;
        flg_d    = flg_q;
        done_d   = 1'b0;
        sp_inv   = 1'b0;
        sp_zero  = 1'b0;
        sp_inf   = 1'b0;
        sp_dz    = 1'b0;
        nexp     = exp_q;
        nman     = quo_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_s_d   = a_s;
                    b_s_d   = b_s;
                    a_e_d   = a_e;
                    b_e_d   = b_e;
                    a_m_d   = a_m;
                    b_m_d   = b_m;
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                case (op_q)
                    OP_MUL: begin
                        if ((a_zero && b_inf) || (a_inf && b_zero)) sp_inv  = 1'b1;
                        else if (a_zero || b_zero)                  sp_zero = 1'b1;
                        else if (a_inf || b_inf)                    sp_inf  = 1'b1;
                    end
                    OP_DIV: begin
                        if ((a_zero && b_zero) || (a_inf && b_inf)) sp_inv = 1'b1;
                        else if (b_zero) begin
                            sp_inf = 1'b1;
                            sp_dz  = 1'b1;
                        end
                        else if (a_zero || b_inf)                   sp_zero = 1'b1;
                        else if (a_inf)                             sp_inf  = 1'b1;
                    end
                    OP_SQRT: begin
                        if (a_zero)      sp_zero = 1'b1;
                        else if (!a_s_q) sp_inv  = 1'b1;
                        else if (a_inf)  sp_inf  = 1'b1;
                    end
                    default: sp_inv = 1'b1;
                endcase

                pr_s_d = sgn;
                pflg_d = '0;
                if (sp_inv || sp_zero) begin
                    pr_e_d         = E_ZERO;
                    pr_m_d         = M_ONE;
                    pflg_d[F_ZERO] = 1'b1;
                    pflg_d[F_INV]  = sp_inv;
                    state_d        = S_DONE;
                end else if (sp_inf) begin
                    pr_e_d         = E_INF;
                    pr_m_d         = M_ONE;
                    pflg_d[F_DZ]   = sp_dz;
                    state_d        = S_DONE;
                end else begin
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = '0;
                    state_d = S_ITER;
                    case (op_q)
                        OP_MUL: begin
                            prod_d = {{MAN_W{1'b0}}, b_m_q};
                            exp_d  = a_ex + b_ex;
                        end
                        OP_DIV: begin
                            // Keep the quotient in [1,2) by doubling a small dividend.
                            if (a_m_q < b_m_q) begin
                                rem_d = {2'b00, a_m_q, 1'b0};
                                exp_d = a_ex - b_ex - X_ONE;
                            end else begin
                                rem_d = {3'b000, a_m_q};
                                exp_d = a_ex - b_ex;
                            end
                        end
                        default: begin
                            prod_d = a_e_q[0] ? {a_m_q, 1'b0, {(MAN_W-1){1'b0}}}
                                              : {1'b0, a_m_q, {(MAN_W-1){1'b0}}};
                            exp_d  = sq_ex >>> 1;
                        end
                    endcase
                end
            end

            S_ITER: begin
                case (op_q)
                    OP_MUL: begin
                        prod_d = {mul_sum, prod_q[MAN_W-1:1]};
                    end
                    OP_DIV: begin
                        quo_d = {quo_q[MAN_W-2:0], div_ge};
                        rem_d = {div_sub[MAN_W+1:0], 1'b0};
                    end
                    default: begin
                        rem_d  = sq_ge ? (sq_rem - sq_trial) : sq_rem;
                        quo_d  = {quo_q[MAN_W-2:0], sq_ge};
                        prod_d = {prod_q[2*MAN_W-3:0], 2'b00};
                    end
                endcase
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) state_d = S_NORM;
            end

            S_NORM: begin
                if (op_q == OP_MUL) begin
                    if (prod_q[2*MAN_W-1]) begin
                        nman = prod_q[2*MAN_W-1:MAN_W];
                        nexp = exp_q + X_ONE;
                    end else begin
                        nman = prod_q[2*MAN_W-2:MAN_W-1];
                        nexp = exp_q;
                    end
                end
                pr_s_d = sgn;
                pflg_d = '0;
                if (nexp > E_MAX) begin
                    pr_e_d         = E_INF;
                    pr_m_d         = M_ONE;
                    pflg_d[F_OVF]  = 1'b1;
                end else if (nexp < E_MIN) begin
                    pr_e_d         = E_ZERO;
                    pr_m_d         = M_ONE;
                    pflg_d[F_UNF]  = 1'b1;
                    pflg_d[F_ZERO] = 1'b1;
                end else begin
                    pr_e_d = nexp[EXP_W-1:0];
                    pr_m_d = nman;
                end
                state_d = S_DONE;
            end

            S_DONE: begin
                res_s_d = pr_s_q;
                res_e_d = pr_e_q;
                res_m_d = pr_m_q;
                flg_d   = pflg_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_s_q   <= 1'b0;
            b_s_q   <= 1'b0;
            a_e_q   <= '0;
            b_e_q   <= '0;
            a_m_q   <= '0;
            b_m_q   <= '0;
            exp_q   <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            pr_s_q  <= 1'b0;
            pr_e_q  <= '0;
            pr_m_q  <= '0;
            pflg_q  <= '0;
            res_s_q <= 1'b0;
            res_e_q <= '0;
            res_m_q <= '0;
            flg_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_s_q   <= a_s_d;
            b_s_q   <= b_s_d;
            a_e_q   <= a_e_d;
            b_e_q   <= b_e_d;
            a_m_q   <= a_m_d;
            b_m_q   <= b_m_d;
            exp_q   <= exp_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            pr_s_q  <= pr_s_d;
            pr_e_q  <= pr_e_d;
            pr_m_q  <= pr_m_d;
            pflg_q  <= pflg_d;
            res_s_q <= res_s_d;
            res_e_q <= res_e_d;
            res_m_q <= res_m_d;
            flg_q   <= flg_d;
            done_q  <= done_d;
        end
    end

    assign res_s          = res_s_q;
    assign res_e          = res_e_q;
    assign res_m          = res_m_q;
    assign zero_flag      = flg_q[F_ZERO];
    assign overflow_flag  = flg_q[F_OVF];
    assign underflow_flag = flg_q[F_UNF];
    assign div_zero_flag  = flg_q[F_DZ];
    assign invalid_flag   = flg_q[F_INV];
    assign idle           = (state_q == S_IDLE);
    assign done           = done_q;

endmodule
